// File: rtl/answer_check_module.sv
// Purpose: judge debounced button presses against the melody, emit success/fail pulses.
// Latency: debounced change at t+2+DEBOUNCE_CYCLES, verdict pulse registered one cycle later.
// Backpressure: presses arriving while busy=1 or outside READY are discarded until released.
module answer_check_module #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] MELODY          = 16'h46E4,
  parameter logic [2:0]  MIN_LAST        = 3'd2,
  parameter logic [2:0]  MAX_LAST        = 3'd7,
  parameter int unsigned BUSY_WAIT       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_in,
  input  logic       busy,
  output logic       success,
  output logic       fail,
  output logic [2:0] pressed_note,
  output logic [2:0] expect_index,
  output logic [2:0] last_index,
  output logic       won
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {READY, HOLD, WAIT_BUSY, WAIT_IDLE} state_t;

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0]    deb_q, deb_d, deb_last_q, deb_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    expect_q, expect_d, last_q, last_d, note_q, note_d;
  logic          won_q, won_d, success_q, success_d, fail_q, fail_d;
  logic          verdict_q, verdict_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          press_evt;
  logic [2:0]    btn_code;
  logic [2:0]    exp_code;

  // Synchronizer and vector debounce: load only after the vector has been stable long enough.
  always_comb begin
    sync1_d    = btn_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    deb_last_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((cnt_q == CNT_MAX) && (sync2_q == prev_q) && (sync2_q != deb_q)) begin
      deb_d = sync2_q;
    end
  end

  // Decode the debounced vector and the note expected at the current index.
  always_comb begin
    press_evt = (deb_q != 4'd0) && (deb_last_q == 4'd0);
    exp_code  = {1'b0, MELODY[{expect_q, 1'b0} +: 2]} + 3'd1;
    case (deb_q)
      4'b0001: btn_code = 3'd1;
      4'b0010: btn_code = 3'd2;
      4'b0100: btn_code = 3'd3;
      4'b1000: btn_code = 3'd4;
      default: btn_code = 3'd0;
    endcase
  end

  // Game FSM: judge a fresh press in READY, then wait for release and for the jingle.
  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    last_d    = last_q;
    won_d     = won_q;
    note_d    = note_q;
    verdict_d = verdict_q;
    wait_d    = wait_q;
    success_d = 1'b0;
    fail_d    = 1'b0;
    case (state_q)
      READY: begin
        if (press_evt && !busy) begin
          won_d     = 1'b0;
          note_d    = btn_code;
          verdict_d = 1'b0;
          state_d   = HOLD;
          if ((btn_code == 3'd0) || (btn_code != exp_code)) begin
            fail_d    = 1'b1;
            expect_d  = 3'd0;
            verdict_d = 1'b1;
          end else if (expect_q < last_q) begin
            expect_d = expect_q + 3'd1;
          end else begin
            success_d = 1'b1;
            expect_d  = 3'd0;
            verdict_d = 1'b1;
            if (last_q < MAX_LAST) begin
              last_d = last_q + 3'd1;
            end else begin
              won_d  = 1'b1;
              last_d = MIN_LAST;
            end
          end
        end
      end
      HOLD: begin
        wait_d = '0;
        if (deb_q == 4'd0) begin
          state_d = verdict_q ? WAIT_BUSY : READY;
        end
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          state_d = READY;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!busy) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      deb_last_q <= '0;
      cnt_q      <= '0;
      state_q    <= READY;
      expect_q   <= 3'd0;
      last_q     <= MIN_LAST;
      won_q      <= 1'b0;
      note_q     <= 3'd0;
      verdict_q  <= 1'b0;
      wait_q     <= '0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      deb_last_q <= deb_last_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      expect_q   <= expect_d;
      last_q     <= last_d;
      won_q      <= won_d;
      note_q     <= note_d;
      verdict_q  <= verdict_d;
      wait_q     <= wait_d;
      success_q  <= success_d;
      fail_q     <= fail_d;
    end
  end

  // Reset masks a pulse registered just before it, so none shows in the reset cycle.
  assign success      = success_q && !reset;
  assign fail         = fail_q && !reset;
  assign pressed_note = (state_q == HOLD) ? note_q : 3'd0;
  assign expect_index = expect_q;
  assign last_index   = last_q;
  assign won          = won_q;

endmodule

// File: tb/tb_answer_check_module.sv
// Bench for answer_check_module with a short debounce window.
// Verdict pulses are predicted into a queue and popped when the DUT pulses.
// Button/busy stimulus is a linear directed sequence.
module tb_answer_check_module;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic       busy;
  logic       success, fail;
  logic [2:0] pressed_note, expect_index, last_index;
  logic       won;

  int total = 0;
  int bad   = 0;

  // expected verdicts, {success, fail}
  logic [1:0] vq[$];
  logic       prev_pulse = 1'b0;

  int mel[8] = '{1, 2, 3, 4, 3, 2, 1, 2};
  int exp_m, last_m;
  bit won_m;

  answer_check_module #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .busy         (busy),
    .success      (success),
    .fail         (fail),
    .pressed_note (pressed_note),
    .expect_index (expect_index),
    .last_index   (last_index),
    .won          (won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse monitor: every pulse must match the oldest predicted verdict.
  always @(negedge clk) begin
    if (success || fail) begin
      total++;
      assert (!(success && fail) && !prev_pulse) else begin
        bad++;
        $error("FAIL pulse_shape observed=%b%b prev=%b expected=single isolated pulse", success, fail, prev_pulse);
      end
      total++;
      assert (vq.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed=%b%b expected=none", success, fail);
      end
      if (vq.size() != 0) begin
        logic [1:0] e;
        e = vq.pop_front();
        total++;
        assert ({success, fail} === e) else begin
          bad++;
          $error("FAIL verdict observed=%b%b expected=%b", success, fail, e);
        end
      end
    end
    prev_pulse = success || fail;
  end

  task automatic model_reset();
    exp_m  = 0;
    last_m = 2;
    won_m  = 1'b0;
  endtask

  // Reference behaviour of one accepted press.
  task automatic model_press(input logic [3:0] vec, output logic [2:0] note, output bit verdict);
    int code;
    code    = 0;
    verdict = 1'b0;
    won_m   = 1'b0;
    for (int i = 0; i < 4; i++) if (vec[i]) code = i + 1;
    if ($countones(vec) != 1) begin
      note = 3'd0;
      vq.push_back(2'b01);
      exp_m   = 0;
      verdict = 1'b1;
    end else begin
      note = 3'(code);
      if (code != mel[exp_m]) begin
        vq.push_back(2'b01);
        exp_m   = 0;
        verdict = 1'b1;
      end else if (exp_m < last_m) begin
        exp_m = exp_m + 1;
      end else begin
        vq.push_back(2'b10);
        exp_m   = 0;
        verdict = 1'b1;
        if (last_m < 7) last_m = last_m + 1;
        else begin
          won_m  = 1'b1;
          last_m = 2;
        end
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_expect"}, 8'(expect_index), 8'(exp_m));
    chk({tag, "_last"},   8'(last_index),   8'(last_m));
    chk({tag, "_won"},    8'(won),          8'(won_m));
  endtask

  task automatic chk_reset_vals();
    chk("rst_success", 8'(success),      8'd0);
    chk("rst_fail",    8'(fail),         8'd0);
    chk("rst_note",    8'(pressed_note), 8'd0);
    chk("rst_expect",  8'(expect_index), 8'd0);
    chk("rst_last",    8'(last_index),   8'd2);
    chk("rst_won",     8'(won),          8'd0);
  endtask

  // One accepted press: hold, release, then optionally play the jingle via busy.
  task automatic do_press(input logic [3:0] vec, input bit use_busy);
    logic [2:0] ne;
    bit v;
    model_press(vec, ne, v);
    btn_in = vec;
    cycles(10);
    chk("pressed_note", 8'(pressed_note), 8'(ne));
    btn_in = 4'd0;
    cycles(10);
    if (v && use_busy) begin
      busy = 1'b1;
      cycles(10);
      busy = 1'b0;
      cycles(3);
    end else if (v) begin
      cycles(20);
    end else begin
      cycles(2);
    end
    chk_state("press");
  endtask

  initial begin
    logic [2:0] ne;
    bit v;
    reset  = 1'b1;
    btn_in = 4'd0;
    busy   = 1'b0;
    model_reset();
    cycles(3);
    chk_reset_vals();
    reset = 1'b0;
    cycles(2);

    // Notes 1,2,3: index 1,2 then success into round 3.
    do_press(4'b0001, 1'b1);
    do_press(4'b0010, 1'b1);
    do_press(4'b0100, 1'b1);

    // Correct then wrong note.
    do_press(4'b0001, 1'b1);
    do_press(4'b0100, 1'b1);

    // Two buttons at once.
    do_press(4'b0011, 1'b1);

    // Two-cycle glitch must not register.
    btn_in = 4'b0001;
    cycles(2);
    btn_in = 4'd0;
    cycles(12);
    chk("glitch_note", 8'(pressed_note), 8'd0);
    chk_state("glitch");

    // Press while busy is ignored; must release and press again.
    busy   = 1'b1;
    btn_in = 4'b0001;
    cycles(10);
    chk("busy_note", 8'(pressed_note), 8'd0);
    chk_state("busy_ignored");
    busy = 1'b0;
    cycles(3);
    chk_state("busy_dropped");
    btn_in = 4'd0;
    cycles(10);
    do_press(4'b0001, 1'b1);

    // Reset lands in the cycle a fail verdict would be registered.
    btn_in = 4'b0100;
    cycles(7);
    reset = 1'b1;
    cycles(2);
    btn_in = 4'd0;
    model_reset();
    chk_reset_vals();
    cycles(8);
    reset = 1'b0;
    cycles(2);
    chk_state("after_reset");

    // Full game: rounds with last index 2..7.
    for (int r = 2; r <= 7; r++) begin
      for (int k = 0; k <= r; k++) begin
        do_press(4'b0001 << (mel[k] - 1), 1'b1);
      end
    end
    chk("final_won",  8'(won),        8'd1);
    chk("final_last", 8'(last_index), 8'd2);

    // Next accepted press clears won.
    do_press(4'b0001, 1'b1);

    // Wrong note, no busy: a press during the busy timeout is dropped.
    model_press(4'b1000, ne, v);
    btn_in = 4'b1000;
    cycles(10);
    chk("wrong_note", 8'(pressed_note), 8'(ne));
    btn_in = 4'd0;
    cycles(8);
    btn_in = 4'b0001;
    cycles(10);
    chk("early_note", 8'(pressed_note), 8'd0);
    chk_state("early_dropped");
    btn_in = 4'd0;
    cycles(30);
    do_press(4'b0001, 1'b1);

    cycles(5);
    chk("pending_verdicts", 8'(vq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
